// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the 4-digit common-anode scan path.
package seven_seg_pkg;
  localparam int         NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  // Active-low one-cold anode select for the given digit.
  function automatic logic [3:0] an_sel(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction
endpackage

// File: rtl/seven_seg_scan_tick_gen.sv
// Enable-gated modulo-DIV counter; tick is high on the cycle the count wraps.
module tick_gen #(
  parameter  int DIV = 10,
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          tick,
  output logic [CW-1:0] cnt
);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (en) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/seven_seg_scan.sv
// Double-buffered 4-digit 7-seg scanner with anti-ghost blanking and per-digit blink.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 64,
  parameter int BLINK_HZ     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] dig1,
  input  logic [6:0] dig2,
  input  logic [6:0] dig3,
  input  logic [6:0] dig4,
  input  logic       load,
  input  logic [3:0] blink_mask,
  input  logic       enable,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       frame_done
);
  localparam int SLOT      = CLK_HZ / REFRESH_HZ;
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int SLOT_W    = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SLOT_W-1:0] BLANK_LIM = SLOT_W'(BLANK_CYCLES);

  logic               slot_tick, blink_tick;
  logic [SLOT_W-1:0]  slot_cnt;
  logic [BLINK_W-1:0] blink_cnt_unused;

  tick_gen #(.DIV(SLOT)) u_slot (
    .clk(clk), .rst(rst), .en(enable), .tick(slot_tick), .cnt(slot_cnt)
  );

  tick_gen #(.DIV(BLINK_DIV)) u_blink (
    .clk(clk), .rst(rst), .en(enable), .tick(blink_tick), .cnt(blink_cnt_unused)
  );

  logic [6:0] dig_in   [NUM_DIGITS];
  logic [6:0] shadow_q [NUM_DIGITS];
  logic [6:0] active_q [NUM_DIGITS];
  logic       pending_q, pending_d;
  digit_idx_t idx_q;
  logic       phase_q;
  logic [6:0] seg_q, seg_d;
  logic [3:0] an_q, an_d;
  logic       fd_q, boundary;

  assign dig_in[0] = dig1;
  assign dig_in[1] = dig2;
  assign dig_in[2] = dig3;
  assign dig_in[3] = dig4;

  always_comb begin
    boundary  = slot_tick && (idx_q == digit_idx_t'(NUM_DIGITS - 1));
    // A load on the boundary cycle wins, so the new shadow stays pending for next frame.
    pending_d = pending_q;
    if (load)          pending_d = 1'b1;
    else if (boundary) pending_d = 1'b0;
    seg_d = SEG_BLANK;
    an_d  = AN_OFF;
    if (enable && (slot_cnt >= BLANK_LIM) && !(blink_mask[idx_q] && phase_q)) begin
      an_d  = an_sel(idx_q);
      seg_d = active_q[idx_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= SEG_BLANK;
        active_q[i] <= SEG_BLANK;
      end
      pending_q <= 1'b0;
      idx_q     <= '0;
      phase_q   <= 1'b0;
      seg_q     <= SEG_BLANK;
      an_q      <= AN_OFF;
      fd_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (load)                  shadow_q[i] <= dig_in[i];
        if (boundary && pending_q) active_q[i] <= shadow_q[i];
      end
      pending_q <= pending_d;
      if (slot_tick)  idx_q   <= idx_q + 1'b1;
      if (blink_tick) phase_q <= ~phase_q;
      seg_q <= seg_d;
      an_q  <= an_d;
      fd_q  <= boundary;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign dp         = 1'b1;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed table-driven bench for seven_seg_scan (SLOT=10, BLANK=2, 20-cycle blink phase).
module tb_seven_seg_scan;
  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] dig1, dig2, dig3, dig4;
  logic       load;
  logic [3:0] blink_mask;
  logic       enable;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       frame_done;

  seven_seg_scan #(
    .CLK_HZ(1000), .REFRESH_HZ(100), .BLANK_CYCLES(2), .BLINK_HZ(25)
  ) dut (
    .clk(clk), .rst(rst), .dig1(dig1), .dig2(dig2), .dig3(dig3), .dig4(dig4),
    .load(load), .blink_mask(blink_mask), .enable(enable),
    .seg(seg), .an(an), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        fd;
    logic        upd;
    logic        en;
    logic [3:0]  mask;
    logic        ld;
    logic [27:0] d;
  } vec_t;

  vec_t vq[$];
  int   nchk  = 0;
  int   nfail = 0;
  int   ecount = 0;

  function automatic vec_t row(int c, logic [3:0] a, logic [6:0] s, logic f);
    vec_t v;
    v.cyc = c; v.an = a; v.seg = s; v.fd = f;
    v.upd = 1'b0; v.en = 1'b0; v.mask = 4'h0; v.ld = 1'b0; v.d = '0;
    return v;
  endfunction

  function automatic vec_t act(int c, logic [3:0] a, logic [6:0] s, logic f,
                               logic e, logic [3:0] m, logic l, logic [27:0] d);
    vec_t v;
    v = row(c, a, s, f);
    v.upd = 1'b1; v.en = e; v.mask = m; v.ld = l; v.d = d;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  task automatic chk_pins(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ef);
    chk({tag, "_an"},  32'(an),         32'(ea));
    chk({tag, "_seg"}, 32'(seg),        32'(es));
    chk({tag, "_fd"},  32'(frame_done), 32'(ef));
    chk({tag, "_dp"},  32'(dp),         32'd1);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; enable = 1'b0; blink_mask = 4'h0;
    dig1 = 7'h00; dig2 = 7'h00; dig3 = 7'h00; dig4 = 7'h00;

    // enabled-edge index n: pins after edge n show state after n-1 enabled edges
    vq.push_back(act(  0, 4'hF, 7'h7F, 1'b0, 1'b1, 4'h0, 1'b1, {7'h08, 7'h7F, 7'h01, 7'h79}));
    vq.push_back(row(  1, 4'hF, 7'h7F, 1'b0));
    vq.push_back(row(  3, 4'hE, 7'h7F, 1'b0));
    vq.push_back(row( 40, 4'h7, 7'h7F, 1'b1));
    vq.push_back(row( 41, 4'hF, 7'h7F, 1'b0));
    vq.push_back(row( 43, 4'hE, 7'h08, 1'b0));
    vq.push_back(row( 50, 4'hE, 7'h08, 1'b0));
    vq.push_back(row( 51, 4'hF, 7'h7F, 1'b0));
    vq.push_back(row( 53, 4'hD, 7'h7F, 1'b0));
    vq.push_back(row( 63, 4'hB, 7'h01, 1'b0));
    vq.push_back(row( 73, 4'h7, 7'h79, 1'b0));
    vq.push_back(row( 79, 4'h7, 7'h79, 1'b0));
    vq.push_back(row( 80, 4'h7, 7'h79, 1'b1));
    vq.push_back(row( 81, 4'hF, 7'h7F, 1'b0));
    vq.push_back(row( 83, 4'hE, 7'h08, 1'b0));
    vq.push_back(act( 90, 4'hE, 7'h08, 1'b0, 1'b1, 4'h0, 1'b1, {7'h12, 7'h24, 7'h40, 7'h00}));
    vq.push_back(row(103, 4'hB, 7'h01, 1'b0));
    vq.push_back(row(113, 4'h7, 7'h79, 1'b0));
    vq.push_back(row(120, 4'h7, 7'h79, 1'b1));
    vq.push_back(row(123, 4'hE, 7'h12, 1'b0));
    vq.push_back(act(130, 4'hE, 7'h12, 1'b0, 1'b1, 4'h0, 1'b1, {7'h2A, 7'h15, 7'h3C, 7'h03}));
    vq.push_back(row(133, 4'hD, 7'h24, 1'b0));
    vq.push_back(row(143, 4'hB, 7'h40, 1'b0));
    vq.push_back(row(153, 4'h7, 7'h00, 1'b0));
    vq.push_back(act(159, 4'h7, 7'h00, 1'b0, 1'b1, 4'h0, 1'b1, {7'h11, 7'h22, 7'h33, 7'h44}));
    vq.push_back(row(160, 4'h7, 7'h00, 1'b1));
    vq.push_back(row(163, 4'hE, 7'h2A, 1'b0));
    vq.push_back(row(193, 4'h7, 7'h03, 1'b0));
    vq.push_back(row(200, 4'h7, 7'h03, 1'b1));
    vq.push_back(row(203, 4'hE, 7'h11, 1'b0));
    vq.push_back(row(233, 4'h7, 7'h44, 1'b0));
    vq.push_back(act(240, 4'h7, 7'h44, 1'b1, 1'b1, 4'h5, 1'b0, '0));
    vq.push_back(row(243, 4'hE, 7'h11, 1'b0));
    vq.push_back(row(253, 4'hD, 7'h22, 1'b0));
    vq.push_back(row(263, 4'hF, 7'h7F, 1'b0));
    vq.push_back(row(270, 4'hF, 7'h7F, 1'b0));
    vq.push_back(row(271, 4'hF, 7'h7F, 1'b0));
    vq.push_back(row(273, 4'h7, 7'h44, 1'b0));
    vq.push_back(act(280, 4'h7, 7'h44, 1'b1, 1'b1, 4'h0, 1'b0, '0));
    vq.push_back(row(283, 4'hE, 7'h11, 1'b0));
    vq.push_back(act(285, 4'hE, 7'h11, 1'b0, 1'b0, 4'h0, 1'b0, '0));
    vq.push_back(row(286, 4'hF, 7'h7F, 1'b0));
    vq.push_back(act(290, 4'hF, 7'h7F, 1'b0, 1'b0, 4'h0, 1'b1, {7'h01, 7'h02, 7'h04, 7'h08}));
    vq.push_back(row(293, 4'hF, 7'h7F, 1'b0));
    vq.push_back(act(300, 4'hF, 7'h7F, 1'b0, 1'b1, 4'h0, 1'b0, '0));
    vq.push_back(row(301, 4'hE, 7'h11, 1'b0));
    vq.push_back(row(305, 4'hE, 7'h11, 1'b0));
    vq.push_back(row(306, 4'hF, 7'h7F, 1'b0));
    vq.push_back(row(308, 4'hD, 7'h22, 1'b0));
    vq.push_back(row(334, 4'h7, 7'h44, 1'b0));
    vq.push_back(row(335, 4'h7, 7'h44, 1'b1));
    vq.push_back(row(336, 4'hF, 7'h7F, 1'b0));
    vq.push_back(row(339, 4'hE, 7'h01, 1'b0));
    vq.push_back(row(349, 4'hD, 7'h02, 1'b0));

    repeat (2) @(posedge clk);
    #1;
    chk_pins("reset_hold", 4'hF, 7'h7F, 1'b0);
    rst = 1'b0;
    ecount = 0;

    foreach (vq[k]) begin
      while (ecount < vq[k].cyc) step();
      chk_pins($sformatf("n%0d", vq[k].cyc), vq[k].an, vq[k].seg, vq[k].fd);
      if (vq[k].upd) begin
        enable     = vq[k].en;
        blink_mask = vq[k].mask;
        if (vq[k].ld) begin
          {dig1, dig2, dig3, dig4} = vq[k].d;
          load = 1'b1;
          step();
          load = 1'b0;
        end
      end
    end

    // asynchronous reset while a digit is lit
    #2 rst = 1'b1;
    #1;
    chk_pins("rst_async", 4'hF, 7'h7F, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk_pins("post_rst_n1", 4'hF, 7'h7F, 1'b0);
    step();
    step();
    chk_pins("post_rst_n3", 4'hE, 7'h7F, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
